// File: rtl/ucsbece154b_sdram_ctrl.sv
// Read-only SDRAM controller for instruction-cache block fills.
// Handles power-up init, periodic auto-refresh and ACTIVE/READ/PRECHARGE fills.
module ucsbece154b_sdram_ctrl #(
  parameter int BLOCK_WORDS      = 4,
  parameter int COL_BITS         = 9,
  parameter int BANK_BITS        = 2,
  parameter int ROW_BITS         = 13,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 7,
  parameter int T_MRD            = 2,
  parameter int CAS_LAT          = 2,
  parameter int INIT_WAIT        = 100,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          MemReadAddress,
  input  logic                 MemReadRequest,
  output logic [31:0]          MemDataOut,
  output logic                 MemDataReady,
  output logic                 SdramCs_n,
  output logic                 SdramRas_n,
  output logic                 SdramCas_n,
  output logic                 SdramWe_n,
  output logic [BANK_BITS-1:0] SdramBa,
  output logic [ROW_BITS-1:0]  SdramAddr,
  input  logic [31:0]          SdramDq
);

  localparam int LW = BANK_BITS + COL_BITS;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [15:0] W_INIT = 16'(INIT_WAIT - 1);
  localparam logic [15:0] W_RP   = 16'(T_RP - 1);
  localparam logic [15:0] W_RFC  = 16'(T_RFC - 1);
  localparam logic [15:0] W_MRD  = 16'(T_MRD - 1);
  localparam logic [15:0] W_RCD  = 16'(T_RCD - 1);
  localparam logic [15:0] W_CAS  = 16'(CAS_LAT - 1);
  localparam logic [15:0] W_BURST = 16'(BLOCK_WORDS - 1);
  localparam logic [15:0] W_REFI = 16'(REFRESH_INTERVAL - 1);

  // Mode register: CAS latency at [6:4], sequential burst, BL=4.
  localparam logic [ROW_BITS-1:0] MODE_WORD = ROW_BITS'({3'(CAS_LAT), 1'b0, 3'b010});
  localparam logic [ROW_BITS-1:0] A10_ALL   = ROW_BITS'(1 << 10);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_LMR,
    S_IDLE, S_REF, S_ACT, S_READ, S_DATA, S_PRE
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BANK_BITS-1:0] ba_q, ba_d;
  logic [ROW_BITS-1:0]  addr_q, addr_d;
  logic                 rdy_q, rdy_d;
  logic [31:0]          dout_q, dout_d;
  logic [LW-1:0]        lat_q, lat_d;

  logic [15:0]          rcnt_q;
  logic                 ref_en_q, pend_q;
  logic                 ref_start, pend_clr, ref_exp;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{MemReadAddress[31:2+LW+ROW_BITS], MemReadAddress[1:0]};

  assign {SdramCs_n, SdramRas_n, SdramCas_n, SdramWe_n} = cmd_q;
  assign SdramBa      = ba_q;
  assign SdramAddr    = addr_q;
  assign MemDataReady = rdy_q;
  assign MemDataOut   = dout_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    cmd_d     = CMD_NOP;
    ba_d      = '0;
    addr_d    = '0;
    rdy_d     = 1'b0;
    dout_d    = dout_q;
    lat_d     = lat_q;
    ref_start = 1'b0;
    pend_clr  = 1'b0;
    case (state_q)
      S_INIT_WAIT: if (cnt_q == W_INIT) begin
        cmd_d = CMD_PRE; addr_d = A10_ALL; state_d = S_INIT_PRE; cnt_d = '0;
      end
      S_INIT_PRE: if (cnt_q == W_RP) begin
        cmd_d = CMD_REF; state_d = S_INIT_REF1; cnt_d = '0;
      end
      S_INIT_REF1: if (cnt_q == W_RFC) begin
        cmd_d = CMD_REF; state_d = S_INIT_REF2; cnt_d = '0;
      end
      S_INIT_REF2: if (cnt_q == W_RFC) begin
        cmd_d = CMD_LMR; addr_d = MODE_WORD; state_d = S_INIT_LMR; cnt_d = '0;
      end
      S_INIT_LMR: if (cnt_q == W_MRD) begin
        state_d = S_IDLE; cnt_d = '0; ref_start = 1'b1;
      end
      S_IDLE: begin
        cnt_d = '0;
        // Pending refresh wins over a waiting fill.
        if (pend_q) begin
          cmd_d = CMD_REF; state_d = S_REF; pend_clr = 1'b1;
        end else if (MemReadRequest) begin
          cmd_d   = CMD_ACT;
          ba_d    = MemReadAddress[2+COL_BITS +: BANK_BITS];
          addr_d  = MemReadAddress[2+LW +: ROW_BITS];
          lat_d   = MemReadAddress[2 +: LW];
          state_d = S_ACT;
        end
      end
      S_REF: if (cnt_q == W_RFC) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      S_ACT: if (cnt_q == W_RCD) begin
        cmd_d   = CMD_RD;
        ba_d    = lat_q[COL_BITS +: BANK_BITS];
        addr_d  = ROW_BITS'({lat_q[COL_BITS-1:2], 2'b00});
        state_d = S_READ; cnt_d = '0;
      end
      S_READ: if (cnt_q == W_CAS) begin
        state_d = S_DATA; cnt_d = '0;
      end
      S_DATA: begin
        rdy_d  = 1'b1;
        dout_d = SdramDq;
        // Close the row while the last word is being presented.
        if (cnt_q == W_BURST) begin
          cmd_d = CMD_PRE; addr_d = A10_ALL; state_d = S_PRE; cnt_d = '0;
        end
      end
      S_PRE: if (cnt_q == W_RP) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      default: begin
        state_d = S_INIT_WAIT; cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      dout_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      lat_q   <= lat_d;
    end
  end

  // Refresh timer runs free once init is done; the flag never queues more than one.
  assign ref_exp = ref_en_q && (rcnt_q == W_REFI);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rcnt_q   <= '0;
      ref_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (ref_start) ref_en_q <= 1'b1;
      if (ref_en_q) rcnt_q <= ref_exp ? 16'd0 : rcnt_q + 16'd1;
      pend_q <= ref_exp | (pend_q & ~pend_clr);
    end
  end

endmodule

// File: tb/tb_ucsbece154b_sdram_ctrl.sv
// Bench for ucsbece154b_sdram_ctrl: randomized cache traffic checked every cycle
// against a schedule-based model of the command/data timeline.
module tb_ucsbece154b_sdram_ctrl;

  localparam int IW = 100, TRCD = 2, TRP = 2, TRFC = 7, TMRD = 2, CAS = 2, RI = 50;
  localparam int IDLE0 = IW + TRP + 2*TRFC + TMRD;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [31:0] addr = '0, dq = '0;
  logic [31:0] dout;
  logic        rdy, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] saddr;

  always #5 clk = ~clk;

  ucsbece154b_sdram_ctrl #(
    .BLOCK_WORDS(4), .COL_BITS(9), .BANK_BITS(2), .ROW_BITS(13),
    .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .CAS_LAT(CAS),
    .INIT_WAIT(IW), .REFRESH_INTERVAL(RI)
  ) dut (
    .Clk(clk), .Reset(rst),
    .MemReadAddress(addr), .MemReadRequest(req),
    .MemDataOut(dout), .MemDataReady(rdy),
    .SdramCs_n(cs_n), .SdramRas_n(ras_n), .SdramCas_n(cas_n), .SdramWe_n(we_n),
    .SdramBa(ba), .SdramAddr(saddr), .SdramDq(dq)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the first cycle with Reset low.
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Model: expected command per cycle, capture cycles, next IDLE cycle.
  logic [18:0] cmd_at [int];
  bit          cap_at [int];
  int          idle_at;
  bit          pend;
  logic        exp_rdy;
  logic [31:0] exp_dout;

  function automatic void model_reset();
    cmd_at.delete();
    cap_at.delete();
    pend    = 1'b0;
    cmd_at[IW]                = {C_PRE, 2'b00, 13'h400};
    cmd_at[IW+TRP]            = {C_REF, 15'b0};
    cmd_at[IW+TRP+TRFC]       = {C_REF, 15'b0};
    cmd_at[IW+TRP+2*TRFC]     = {C_LMR, 2'b00, 13'((CAS << 4) | 2)};
    idle_at = IDLE0;
  endfunction

  function automatic void sched_fill(input int c, input logic [31:0] a);
    logic [29:0] wa;
    int rd;
    wa = a[31:2];
    rd = c + 1 + TRCD;
    cmd_at[c+1] = {C_ACT, wa[10:9], wa[23:11]};
    cmd_at[rd]  = {C_RD, wa[10:9], 4'b0000, wa[8:2], 2'b00};
    for (int k = 0; k < 4; k++) cap_at[rd+CAS+k] = 1'b1;
    cmd_at[c+5+TRCD+CAS] = {C_PRE, 2'b00, 13'h400};
    idle_at = c + 5 + TRCD + CAS + TRP;
  endfunction

  initial begin
    exp_rdy  = 1'b0;
    exp_dout = '0;
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk($sformatf("cmd@%0d", cyc), {45'b0, cs_n, ras_n, cas_n, we_n, ba, saddr},
          {45'b0, cmd_at.exists(cyc) ? cmd_at[cyc] : {C_NOP, 15'b0}});
      chk($sformatf("data@%0d", cyc), {31'b0, rdy, dout}, {31'b0, exp_rdy, exp_dout});
      #3;
      if (rst) begin
        model_reset();
        exp_rdy  = 1'b0;
        exp_dout = '0;
      end else begin
        exp_rdy = cap_at.exists(cyc);
        if (exp_rdy) exp_dout = dq;
        if (cyc > IDLE0 && (cyc - IDLE0) % RI == 0) pend = 1'b1;
        if (cyc == idle_at) begin
          if (pend) begin
            pend = 1'b0;
            cmd_at[cyc+1] = {C_REF, 15'b0};
            idle_at = cyc + 1 + TRFC;
          end else if (req) begin
            sched_fill(cyc, addr);
          end else begin
            idle_at = cyc + 1;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    dq = $urandom;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin tick(); g++; end
    chk("wait_cyc", {63'b0, cyc >= n}, 64'd1);
  endtask

  task automatic wait_rdy();
    int g = 0;
    while (!rdy && g < 300) begin tick(); g++; end
    chk("rdy_seen", {63'b0, rdy}, 64'd1);
  endtask

  task automatic wait_rdy_low();
    int g = 0;
    while (rdy && g < 300) begin tick(); g++; end
    chk("rdy_low", {63'b0, rdy}, 64'd0);
  endtask

  initial begin
    bit prev = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Request during init must wait until IDLE; then a back-to-back pair.
    wait_cyc(50);
    req = 1'b1; addr = 32'h0000_1234;
    wait_rdy();
    addr = $urandom;
    wait_rdy_low();
    wait_rdy();
    req = 1'b0;

    // Request raised in the same cycle refresh becomes pending.
    wait_cyc(IDLE0 + RI);
    req = 1'b1; addr = $urandom;
    wait_rdy();
    req = 1'b0;

    // Timer expires in the middle of this fill.
    wait_cyc(IDLE0 + 2*RI - 6);
    req = 1'b1; addr = $urandom;
    wait_rdy();
    req = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      tick();
      if (req && rdy && !prev) begin
        if ($urandom_range(0, 1) == 0) req = 1'b0;
        else addr = $urandom;
      end else if (!req && $urandom_range(0, 5) == 0) begin
        req = 1'b1; addr = $urandom;
      end
      prev = rdy;
    end

    // Reset during the second word of a burst.
    wait_rdy_low();
    if (!req) begin req = 1'b1; addr = $urandom; end
    wait_rdy();
    tick();
    chk("rdy2", {63'b0, rdy}, 64'd1);
    rst = 1'b1; req = 1'b0;
    tick();
    rst = 1'b0;

    wait_cyc(50);
    req = 1'b1; addr = $urandom;
    wait_rdy();
    req = 1'b0;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_sdram_ctrl.md
# ucsbece154b_sdram_ctrl

Read-only SDRAM controller directly downstream of the instruction cache. It accepts block-fill requests on the cache's memory port (`MemReadAddress`/`MemReadRequest`) and issues ACTIVATE/READ/PRECHARGE to a single-rank SDRAM. It returns `BLOCK_WORDS` words, one per cycle, on `MemDataOut`/`MemDataReady`. It also owns power-up initialization and periodic auto-refresh.

## Interface
- `BLOCK_WORDS`, 4: words per fill; equals programmed burst length (only 4 supported)
- `COL_BITS`, 9; `BANK_BITS`, 2; `ROW_BITS`, 13: SDRAM geometry
- `T_RCD`, 2; `T_RP`, 2; `T_RFC`, 7; `T_MRD`, 2: command spacing in cycles
- `CAS_LAT`, 2: CAS latency (2 or 3)
- `INIT_WAIT`, 100: NOP cycles after reset before init commands
- `REFRESH_INTERVAL`, 780: cycles between refresh requests
- `Clk`  in  1  single clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `MemReadAddress`  in  32  byte address of requested word
- `MemReadRequest`  in  1  level request from cache
- `MemDataOut`  out  32  returned word
- `MemDataReady`  out  1  `MemDataOut` valid this cycle
- `SdramCs_n`, `SdramRas_n`, `SdramCas_n`, `SdramWe_n`  out  1 each  command pins
- `SdramBa`  out  `BANK_BITS`  bank address
- `SdramAddr`  out  `ROW_BITS`  row/column/mode address
- `SdramDq`  in  32  read data from device

## Operation
- **Command encoding** ({CS_n, RAS_n, CAS_n, WE_n}):
  - NOP 0111
  - ACTIVE 0011
  - READ 0101
  - PRECHARGE 0010, with `SdramAddr[10]`=1 (all banks)
  - REFRESH 0001
  - LOAD MODE 0000
- **Outputs:** all are registered. `SdramBa`/`SdramAddr` are 0 unless the command needs them.
- **Address map:** word address wa = `MemReadAddress[31:2]`.
  - col = wa[8:0], bank = wa[10:9], row = wa[23:11]; wa[29:24] is ignored.
  - READ column = col with bits [1:0] forced to 0 (block-aligned).
  - Words return in ascending order. A10=0 on READ (no auto-precharge).
- **Init sequence:** NOP ×`INIT_WAIT`, then:
  - PRECHARGE-all; next command `T_RP` later
  - REFRESH; next `T_RFC` later
  - REFRESH; next `T_RFC` later
  - LOAD MODE with `SdramAddr` = {CAS_LAT at [6:4], sequential, BL=4 at [2:0]} (13'h022 for CAS 2)
  - IDLE entered `T_MRD` later.
- **States:** INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR, IDLE, REF, ACT, READ, DATA, PRE.
  - Each state counts its own wait cycles with NOPs.
- **Refresh:**
  - The counter starts at IDLE entry after init and counts every cycle in every state.
  - At `REFRESH_INTERVAL` it sets `refresh_pending` and reloads.
  - A second expiry while the flag is already set does not queue a second refresh.
- **IDLE priority:**
  - `refresh_pending` beats `MemReadRequest`: issue REFRESH next cycle, clear the flag, NOP for `T_RFC-1` cycles, return to IDLE.
  - Otherwise, if `MemReadRequest`=1, latch the address and start a fill.
- **Fill sequence:**
  - ACTIVE (row, bank), then READ `T_RCD` later.
  - Capture `SdramDq` for 4 consecutive cycles starting `CAS_LAT` after READ.
  - PRECHARGE in the cycle the last word is presented; IDLE `T_RP` later.
- **Request protocol:**
  - `MemReadRequest` is sampled only in IDLE.
  - Cache holds request and address until the first `MemDataReady`, and deasserts before the controller re-enters IDLE.
  - A request still high at IDLE re-entry starts a new fill (cache's responsibility).
- **No preemption:** refresh never interrupts a fill, and a fill never interrupts refresh or init. Requests during init or refresh wait.

## Timing
- **Reset values:**
  - Command NOP, `SdramBa`=0, `SdramAddr`=0
  - `MemDataReady`=0, `MemDataOut`=0
  - State INIT_WAIT, refresh counter 0, pending flag cleared.
- **Reset mid-operation:** the next cycle shows reset values. Any in-flight burst is dropped (no further `MemDataReady`) and the full init sequence repeats.
- **Init completion:** cycle 0 = first cycle with `Reset`=0. With defaults: PRECHARGE at 100, REFRESH at 102 and 109, LOAD MODE at 116, IDLE at 118.
- **Fill timing:** request seen in IDLE at cycle c.
  - ACTIVE at c+1, READ at c+1+T_RCD.
  - Word k on `SdramDq` at c+1+T_RCD+CAS_LAT+k.
  - `MemDataReady`=1 with word k at c+2+T_RCD+CAS_LAT+k, k=0..3.
  - PRECHARGE at c+5+T_RCD+CAS_LAT; IDLE at that cycle + `T_RP`.
  - Defaults: ready c+6..c+9, PRECHARGE c+9, IDLE c+11.
- **Output hold:** `MemDataReady` is exactly 4 contiguous cycles per fill. `MemDataOut` holds the last word after the burst.

## Test plan
- **Init:** reset 3 cycles, release → PRECHARGE (A10=1) at 100, REFRESH at 102 and 109, LOAD MODE `SdramAddr`=13'h022 at 116; only NOP otherwise; a request held from cycle 50 is not served before 118.
- **Basic fill:** request 0x0000_1234 seen in IDLE at 118 →
  - ACTIVE bank 2 row 0 at 119; READ bank 2 `SdramAddr`=0x08C at 121.
  - Drive `SdramDq` 0xA0..0xA3 at 123..126 → `MemDataReady` 124..127 with 0xA0..0xA3.
  - PRECHARGE at 127.
- **Back-to-back:** request held continuously through two fills → second ACTIVE issued at the cycle after IDLE re-entry (first fill IDLE at 129 → ACTIVE 130).
- **Refresh priority:** `REFRESH_INTERVAL`=50; request asserted the same IDLE cycle `refresh_pending` is set → REFRESH first, ACTIVE exactly `T_RFC`+1 cycles after REFRESH.
- **Refresh deferral:** counter expires mid-fill → burst completes unaltered, REFRESH issued the cycle after IDLE re-entry.
- **Mid-burst reset:** `Reset` asserted after the 2nd `MemDataReady` → no further ready pulses, outputs at reset values next cycle, init repeats from cycle 0.
